// File: rtl/trigger_stage.sv
// One stage of the 32-channel complex trigger: LUT pattern match, programmable sample delay, match/run pulse.
// Define TRIGGER_SERIAL_MODE_EN to add the serial shift-register lookup source selected by cfgSerial.
module trigger_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] dataIn,
    input  logic        validIn,
    input  logic        wrenb,
    input  logic [7:0]  din,
    input  logic        wrConfig,
    input  logic [31:0] config_data,
    input  logic        arm,
    input  logic [1:0]  level,
    input  logic        demux_mode,
    output logic        run,
    output logic        match
);

    typedef enum logic [1:0] {OFF, ARMED, MATCHED} state_t;

    state_t      state;
    logic [15:0] counter;
    logic [15:0] cfg_delay;
    logic [1:0]  cfg_level;
    logic        cfg_start;

    logic [15:0] lut [8];
    logic [7:0]  lut_hit;
    logic [31:0] src;
    logic        check_valid;
    logic        hit;

    // Each nibble LUT is a 16-deep shift chain; no reset so the pattern survives a trigger reset.
    always_ff @(posedge clock) begin
        if (wrenb) begin
            for (int unsigned i = 0; i < 8; i++) begin
                lut[i] <= {lut[i][14:0], din[i]};
            end
        end
    end

`ifdef TRIGGER_SERIAL_MODE_EN
    logic [4:0]  cfg_channel;
    logic        cfg_serial;
    logic [31:0] sr;
    logic        sr_valid;
    logic        cfg_unused;

    always_ff @(posedge clock) begin
        if (validIn) begin
            sr <= {sr[30:0], dataIn[cfg_channel]};
        end
    end

    // Serial lookup runs one cycle behind validIn so it sees the freshly shifted sr.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sr_valid    <= 1'b0;
            cfg_channel <= '0;
            cfg_serial  <= 1'b0;
        end else begin
            sr_valid <= validIn;
            if (wrConfig) begin
                cfg_channel <= config_data[24:20];
                cfg_serial  <= config_data[26];
            end
        end
    end

    assign src         = cfg_serial ? sr : dataIn;
    assign check_valid = cfg_serial ? sr_valid : validIn;
    assign cfg_unused  = &{1'b0, config_data[31:28], config_data[25], config_data[19:18]};
`else
    logic cfg_unused;

    assign src         = dataIn;
    assign check_valid = validIn;
    assign cfg_unused  = &{1'b0, config_data[31:28], config_data[26:18]};
`endif

    always_comb begin
        lut_hit = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            lut_hit[i] = lut[i][src[4*i +: 4]];
        end
    end

    assign hit = demux_mode ? ((&lut_hit[3:0]) | (&lut_hit[7:4])) : (&lut_hit);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= OFF;
            counter   <= '0;
            match     <= 1'b0;
            run       <= 1'b0;
            cfg_delay <= '0;
            cfg_level <= '0;
            cfg_start <= 1'b0;
        end else begin
            match <= 1'b0;
            run   <= 1'b0;
            if (wrConfig) begin
                cfg_delay <= config_data[15:0];
                cfg_level <= config_data[17:16];
                cfg_start <= config_data[27];
            end
            if (arm) begin
                state <= ARMED;
            end else begin
                case (state)
                    ARMED: begin
                        if (check_valid && hit && (level >= cfg_level)) begin
                            state   <= MATCHED;
                            counter <= cfg_delay;
                        end
                    end
                    MATCHED: begin
                        // Zero is tested before decrementing, so the counter never wraps.
                        if (counter == 16'd0) begin
                            state <= OFF;
                            match <= 1'b1;
                            run   <= cfg_start;
                        end else if (validIn) begin
                            counter <= counter - 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trigger_stage.sv
// Scoreboard bench for trigger_stage: stimulus pushes expected fire edges, a monitor checks match/run every cycle.
module tb_trigger_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] dataIn = '0;
    logic        validIn = 1'b0;
    logic        wrenb = 1'b0;
    logic [7:0]  din = '0;
    logic        wrConfig = 1'b0;
    logic [31:0] config_data = '0;
    logic        arm = 1'b0;
    logic [1:0]  level = '0;
    logic        demux_mode = 1'b0;
    logic        run;
    logic        match;

    trigger_stage dut (
        .clock       (clock),
        .reset       (reset),
        .dataIn      (dataIn),
        .validIn     (validIn),
        .wrenb       (wrenb),
        .din         (din),
        .wrConfig    (wrConfig),
        .config_data (config_data),
        .arm         (arm),
        .level       (level),
        .demux_mode  (demux_mode),
        .run         (run),
        .match       (match)
    );

    always #5 clock = ~clock;

    typedef struct {
        int   cyc;
        logic run;
    } exp_t;

    exp_t  exp_q [$];
    int    cyc = 0;
    int    checks = 0;
    int    fails = 0;
    bit    active = 1'b0;
    bit    done = 1'b0;
    string tname = "reset";

    always @(posedge clock) cyc <= cyc + 1;

    // Expected outputs for the edge just taken: a pulse only where the scoreboard holds an entry.
    always @(negedge clock) begin
        if (active) begin
            logic exp_m, exp_r;
            exp_m = 1'b0;
            exp_r = 1'b0;
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                fails++;
                $display("FAIL %s: stale expectation for edge %0d at edge %0d", tname, exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                exp_m = 1'b1;
                exp_r = exp_q[0].run;
                void'(exp_q.pop_front());
            end
            checks++;
            if (match !== exp_m || run !== exp_r) begin
                fails++;
                $display("FAIL %s: edge %0d match=%b run=%b, required match=%b run=%b",
                         tname, cyc, match, run, exp_m, exp_r);
            end
            if (done) begin
                checks++;
                if (exp_q.size() != 0) begin
                    fails++;
                    $display("FAIL %s: %0d expected pulses never seen, required 0", tname, exp_q.size());
                end
                $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
                $finish;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic expect_fire(input int edges_ahead, input logic r);
        exp_t e;
        e.cyc = cyc + edges_ahead;
        e.run = r;
        exp_q.push_back(e);
    endtask

    function automatic logic lut_bit(input logic [31:0] v, input logic [31:0] m,
                                     input int unsigned i, input logic [3:0] a);
        logic [3:0] vn, mn;
        vn = v[4*i +: 4];
        mn = m[4*i +: 4];
        return ((a ^ vn) & mn) == 4'd0;
    endfunction

    // First bit written ends at address 15, so addresses are written 15 down to 0.
    task automatic load_lut(input logic [31:0] v, input logic [31:0] m);
        for (int k = 0; k < 16; k++) begin
            logic [3:0] a;
            a = 4'(15 - k);
            for (int unsigned i = 0; i < 8; i++) din[i] = lut_bit(v, m, i, a);
            wrenb = 1'b1;
            tick();
        end
        wrenb = 1'b0;
    endtask

    task automatic write_cfg(input logic [31:0] c);
        config_data = c;
        wrConfig = 1'b1;
        tick();
        wrConfig = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic sample(input logic [31:0] d);
        dataIn = d;
        validIn = 1'b1;
        tick();
        validIn = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        tick();
        active = 1'b1;
        idle(2);
        reset = 1'b1;
        idle(2);

        // Exact match, delay 0, start set: fires two edges after the sample is presented.
        tname = "exact_match";
        load_lut(32'h1234_5678, 32'hFFFF_FFFF);
        write_cfg(32'h0800_0000);
        do_arm();
        sample(32'h1234_5679);
        idle(3);
        expect_fire(2, 1'b1);
        sample(32'h1234_5678);
        idle(4);
        sample(32'h1234_5678);
        idle(3);

        // Don't-care pattern, delay 3, start clear, back-to-back samples.
        tname = "delay3";
        load_lut(32'h0000_0000, 32'h0000_0000);
        write_cfg(32'h0000_0003);
        do_arm();
        expect_fire(5, 1'b0);
        repeat (6) sample(32'hDEAD_BEEF);
        idle(3);

        // Delay 2 with gaps: only valid samples count down.
        tname = "delay2_gaps";
        write_cfg(32'h0800_0002);
        do_arm();
        expect_fire(6, 1'b1);
        sample(32'h0000_0001);
        idle(1);
        sample(32'h0000_0002);
        idle(1);
        sample(32'h0000_0003);
        idle(4);

        // Level gating.
        tname = "level_gate";
        load_lut(32'hAAAA_5555, 32'hFFFF_FFFF);
        write_cfg(32'h0802_0000);
        level = 2'd1;
        do_arm();
        sample(32'hAAAA_5555);
        idle(3);
        level = 2'd2;
        expect_fire(2, 1'b1);
        sample(32'hAAAA_5555);
        idle(3);
        level = 2'd0;

        // Demux: upper half alone matches in demux mode, not in full-width mode.
        tname = "demux";
        load_lut(32'hBEEF_0000, 32'hFFFF_FFFF);
        write_cfg(32'h0800_0000);
        demux_mode = 1'b1;
        do_arm();
        expect_fire(2, 1'b1);
        sample(32'hBEEF_1234);
        idle(3);
        demux_mode = 1'b0;
        do_arm();
        sample(32'hBEEF_1234);
        idle(3);

        // Arm in the firing cycle wins over the fire.
        tname = "arm_priority";
        do_arm();
        sample(32'hBEEF_0000);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        idle(2);
        expect_fire(2, 1'b1);
        sample(32'hBEEF_0000);
        idle(3);

        // Reset mid-delay clears state and config; no fire without re-arm.
        tname = "reset_mid_delay";
        load_lut(32'h0000_0000, 32'h0000_0000);
        write_cfg(32'h0800_000A);
        do_arm();
        repeat (6) sample(32'h5A5A_5A5A);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        idle(2);
        sample(32'h5A5A_5A5A);
        idle(4);
        do_arm();
        expect_fire(2, 1'b0);
        sample(32'h5A5A_5A5A);
        idle(3);

`ifdef TRIGGER_SERIAL_MODE_EN
        // Serial mode on channel 4: clear sr, then shift the pattern MSB first.
        tname = "serial";
        begin
            logic [31:0] pat;
            pat = 32'hC3A5_0F96;
            load_lut(pat, 32'hFFFF_FFFF);
            write_cfg(32'h0C40_0000);
            repeat (32) sample(32'h0000_0000);
            idle(2);
            do_arm();
            for (int k = 0; k < 32; k++) begin
                logic [31:0] d;
                d = '0;
                d[4] = pat[31 - k];
                if (k == 31) expect_fire(3, 1'b1);
                sample(d);
            end
            idle(4);
        end
`endif

        tname = "final";
        done = 1'b1;
        idle(3);
        $display("FAIL timeout: monitor did not close the run");
        $fatal(1);
    end

endmodule
